// File: rtl/sigma_delta_pkg.sv
// Shared types and arithmetic helpers for the multi-channel sigma-delta modulator.
package sigma_delta_pkg;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic signed [63:0] wide_t;

    function automatic wide_t fb_level(
        input logic [7:0] code,
        input int         width,
        input int         out_width
    );
        wide_t lv;
        lv = wide_t'({56'd0, code}) * 64'sd2 + 64'sd1 - (64'sd1 <<< out_width);
        return lv <<< (width - out_width);
    endfunction

    function automatic logic [7:0] quantise(
        input wide_t v,
        input int    width,
        input int    out_width
    );
        wide_t q;
        wide_t top;
        top = (64'sd1 <<< out_width) - 64'sd1;
        q = (v >>> (width - out_width + 1)) + (64'sd1 <<< (out_width - 1));
        if (q < 64'sd0) begin
            q = 64'sd0;
        end else if (q > top) begin
            q = top;
        end
        return q[7:0];
    endfunction

    function automatic wide_t sat_add(
        input wide_t a,
        input wide_t b,
        input int    iw
    );
        wide_t s;
        wide_t hi;
        wide_t lo;
        s  = a + b;
        hi = (64'sd1 <<< (iw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (iw - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/sd_lfsr16.sv
// 16-bit Fibonacci LFSR, shift-left, used as the dither source.
module sd_lfsr16
    import sigma_delta_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic bit_out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_out = lfsr_q[0];

endmodule

// File: rtl/sigma_delta_mod_mc.sv
// Multi-channel multi-bit sigma-delta modulator, order 1 or 2.
// One shared loop datapath steps each channel in turn per frame.
module sigma_delta_mod_mc
    import sigma_delta_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 1,
    parameter int ORDER     = 2,
    parameter int CHANNELS  = 4,
    parameter int GUARD     = 3,
    parameter int DITHER    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CHANNELS*WIDTH-1:0]     in,
    output logic [CHANNELS*OUT_WIDTH-1:0] sd_out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IW = WIDTH + GUARD + 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RST_CODE_I = 2 ** (OUT_WIDTH - 1);
    localparam logic [OUT_WIDTH-1:0] RST_CODE = OUT_WIDTH'(RST_CODE_I);

    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
        $error("sigma_delta_mod_mc: ORDER must be 1 or 2");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > 8) begin : g_bad_ow
        $error("sigma_delta_mod_mc: OUT_WIDTH must be 1..8");
    end

    state_t                      state_q, state_d;
    logic [CW-1:0]               ch_q, ch_d;
    logic [CHANNELS*WIDTH-1:0]   hold_q, hold_d;
    logic                        out_valid_q, out_valid_d;
    logic                        overrun_q, overrun_d;

    logic signed [IW-1:0]        i1_q   [CHANNELS];
    logic signed [IW-1:0]        i2_q   [CHANNELS];
    logic [OUT_WIDTH-1:0]        code_q [CHANNELS];
    logic signed [WIDTH-1:0]     x_arr  [CHANNELS];

    logic                        run;
    logic                        accept;
    logic                        last;
    logic                        dither_bit;

    wide_t                       x_w, lvl_w, d_w, i1_w, i2_w, v_w;
    logic signed [IW-1:0]        i1_n, i2_n;
    logic [OUT_WIDTH-1:0]        code_n;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign x_arr[k] = hold_q[k*WIDTH +: WIDTH];
        assign sd_out[k*OUT_WIDTH +: OUT_WIDTH] = code_q[k];
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (last) state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run    = (state_q == RUN);
        accept = en && (state_q == IDLE);
        last   = run && (ch_q == CW'(CHANNELS - 1));
    end

    always_comb begin
        hold_d      = accept ? in : hold_q;
        ch_d        = ch_q;
        if (accept) begin
            ch_d = '0;
        end else if (run) begin
            ch_d = ch_q + 1'b1;
        end
        out_valid_d = last;
        overrun_d   = overrun_q | (en & run);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q        <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    sd_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step    (run),
        .bit_out (dither_bit)
    );

    // Shared loop step for the channel selected by ch_q
    always_comb begin
        x_w   = wide_t'(x_arr[ch_q]);
        lvl_w = fb_level(8'(code_q[ch_q]), WIDTH, OUT_WIDTH);
        d_w   = '0;
        d_w[0] = dither_bit & (DITHER != 0);
        i1_w  = sat_add(wide_t'(i1_q[ch_q]) + x_w + d_w, -lvl_w, IW);
        if (ORDER == 2) begin
            i2_w = sat_add(wide_t'(i2_q[ch_q]), i1_w - (lvl_w <<< 1), IW);
        end else begin
            i2_w = wide_t'(i2_q[ch_q]);
        end
        v_w    = (ORDER == 1) ? i1_w : i2_w;
        i1_n   = IW'(i1_w);
        i2_n   = IW'(i2_w);
        code_n = OUT_WIDTH'(quantise(v_w, WIDTH, OUT_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                i1_q[k]   <= '0;
                i2_q[k]   <= '0;
                code_q[k] <= RST_CODE;
            end
        end else if (run) begin
            i1_q[ch_q]   <= i1_n;
            i2_q[ch_q]   <= i2_n;
            code_q[ch_q] <= code_n;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = run;
    assign overrun   = overrun_q;

endmodule
